// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared types and constants for the instruction fetch queue
package inst_fetch_queue_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;
    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        IFQ_FETCH   = 2'b00,
        IFQ_FULL    = 2'b01,
        IFQ_DISCARD = 2'b10
    } ifq_state_e;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } ifq_entry_t;

    function automatic logic [INST_ADDR_W-1:0] next_pc(input logic [INST_ADDR_W-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - memory-controller, redirect and decode signals of the fetch queue
interface inst_fetch_queue_if;
    import inst_fetch_queue_pkg::*;

    logic [INST_ADDR_W-1:0] pc_o;
    logic                   pc_req_o;
    logic                   pc_done_i;
    logic [INST_W-1:0]      inst_i;
    logic                   jump_i;
    logic [INST_ADDR_W-1:0] jump_addr_i;
    logic                   if_valid_o;
    logic [INST_ADDR_W-1:0] if_pc_o;
    logic [INST_W-1:0]      if_inst_o;
    logic                   id_ready_i;

    modport master (
        output pc_o, pc_req_o, if_valid_o, if_pc_o, if_inst_o,
        input  pc_done_i, inst_i, jump_i, jump_addr_i, id_ready_i
    );

    modport slave (
        input  pc_o, pc_req_o, if_valid_o, if_pc_o, if_inst_o,
        output pc_done_i, inst_i, jump_i, jump_addr_i, id_ready_i
    );
endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// rtl/inst_fetch_queue_fifo.sv - ifq_fifo: DEPTH x {pc,inst} queue with push/pop/flush and head data
module ifq_fifo
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  ifq_entry_t               wr_data,
    output ifq_entry_t               head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    ifq_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !flush) mem[wr_ptr] <= wr_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch FSM, fetch PC and decode-side mux around ifq_fifo
// Optional zero-latency empty-queue bypass is enabled by defining IFQ_BYPASS_EN.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int                     DEPTH    = 4,
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy_in,
    inst_fetch_queue_if.master    ifq
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    ifq_state_e             state, state_n;
    logic [INST_ADDR_W-1:0] pc_q, pc_n;
    logic                   busy_q, busy_n;
    logic                   push, pop, flush, bypass, byp_cond, pop_ok;
    logic [CW-1:0]          count;
    logic [CW:0]            cnt_after;
    ifq_entry_t             head;

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data ({pc_q, ifq.inst_i}),
        .head    (head),
        .count   (count)
    );

`ifdef IFQ_BYPASS_EN
    assign byp_cond = (count == '0) && ifq.id_ready_i;
`else
    assign byp_cond = 1'b0;
`endif

    assign pop_ok = (count != '0) && ifq.id_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IFQ_FETCH;
            pc_q   <= RESET_PC;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            pc_q   <= pc_n;
            busy_q <= busy_n;
        end
    end

    // busy_q: a request has been visible for at least one cycle without its done.
    always_comb begin
        state_n   = state;
        pc_n      = pc_q;
        busy_n    = busy_q;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        bypass    = 1'b0;
        cnt_after = {1'b0, count};
        if (rdy_in) begin
            if (ifq.jump_i) begin
                flush  = 1'b1;
                pc_n   = ifq.jump_addr_i;
                busy_n = 1'b0;
                if (state == IFQ_FETCH && busy_q && !ifq.pc_done_i)
                    state_n = IFQ_DISCARD;
                else
                    state_n = IFQ_FETCH;
            end else begin
                case (state)
                    IFQ_FETCH: begin
                        pop = pop_ok;
                        if (ifq.pc_done_i) begin
                            pc_n   = next_pc(pc_q);
                            busy_n = 1'b0;
                            if (byp_cond) bypass = 1'b1;
                            else          push   = 1'b1;
                            cnt_after = {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
                            state_n   = (cnt_after < DEPTH_W) ? IFQ_FETCH : IFQ_FULL;
                        end else begin
                            busy_n = 1'b1;
                        end
                    end
                    IFQ_FULL: begin
                        pop    = pop_ok;
                        busy_n = 1'b0;
                        if (pop_ok) state_n = IFQ_FETCH;
                    end
                    IFQ_DISCARD: begin
                        pop    = pop_ok;
                        busy_n = 1'b0;
                        if (ifq.pc_done_i) state_n = IFQ_FETCH;
                    end
                    default: begin
                        state_n = IFQ_FETCH;
                        busy_n  = 1'b0;
                    end
                endcase
            end
        end
    end

    assign ifq.pc_o       = pc_q;
    assign ifq.pc_req_o   = !rst && rdy_in && (state == IFQ_FETCH);
    assign ifq.if_valid_o = !rst && ((count != '0) || bypass);
    assign ifq.if_pc_o    = rst ? ZERO_WORD : (bypass ? pc_q : head.pc);
    assign ifq.if_inst_o  = rst ? ZERO_WORD : (bypass ? ifq.inst_i : head.inst);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - table and sequence driven scoreboard bench for inst_fetch_queue
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy_in = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [31:0] model_pc = 32'h0;
    logic [63:0] exp_q[$];

    inst_fetch_queue_if ifq();

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk    (clk),
        .rst    (rst),
        .rdy_in (rdy_in),
        .ifq    (ifq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        done;
        logic [31:0] inst;
        logic        ready;
        logic        acc;
        logic        exp_req;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [2:0]  exp_cnt;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // decode-side scoreboard: every accepted pop must match the oldest expected word
    always @(negedge clk) begin
        if (!rst && rdy_in && !ifq.jump_i && ifq.if_valid_o && ifq.id_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra_pop", {ifq.if_pc_o, ifq.if_inst_o}, 64'h0);
            end else begin
                chk("sb_word", {ifq.if_pc_o, ifq.if_inst_o}, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic done, input logic [31:0] inst, input logic ready, input logic acc);
        ifq.pc_done_i  = done;
        ifq.inst_i     = inst;
        ifq.id_ready_i = ready;
        ifq.jump_i     = 1'b0;
        if (acc) begin
            chk("pc_o_at_done", {32'h0, ifq.pc_o}, {32'h0, model_pc});
            chk("req_at_done", {63'h0, ifq.pc_req_o}, 64'h1);
            exp_q.push_back({model_pc, inst});
            model_pc = model_pc + 32'd4;
        end
        step();
        ifq.pc_done_i = 1'b0;
    endtask

    task automatic jmp(input logic [31:0] addr, input logic done);
        ifq.jump_i      = 1'b1;
        ifq.jump_addr_i = addr;
        ifq.pc_done_i   = done;
        ifq.inst_i      = 32'hDEAD_BEEF;
        ifq.id_ready_i  = 1'b1;
        exp_q.delete();
        model_pc = addr;
        step();
        ifq.jump_i    = 1'b0;
        ifq.pc_done_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy_in = 1'b1;
        ifq.pc_done_i = 1'b0; ifq.inst_i = '0; ifq.jump_i = 1'b0;
        ifq.jump_addr_i = '0; ifq.id_ready_i = 1'b0;
        step();
        chk("rst_pc", {32'h0, ifq.pc_o}, 64'h0);
        chk("rst_req", {63'h0, ifq.pc_req_o}, 64'h0);
        chk("rst_valid", {63'h0, ifq.if_valid_o}, 64'h0);
        rst = 1'b0;
        exp_q.delete();
        model_pc = 32'h0;
        #1;
        chk("post_rst_req", {63'h0, ifq.pc_req_o}, 64'h1);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n && exp_q.size() != 0; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_left", exp_q.size(), 64'h0);
        chk("drain_valid", {63'h0, ifq.if_valid_o}, 64'h0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'hB0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 3'd1};
        tbl[1] = '{1'b1, 32'hB1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 3'd2};
        tbl[2] = '{1'b1, 32'hB2, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 3'd3};
        tbl[3] = '{1'b1, 32'hB3, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 3'd4};
        tbl[4] = '{1'b1, 32'hB4, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10, 3'd4};
        tbl[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 3'd3};
        tbl[6] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 3'd3};
        tbl[7] = '{1'b1, 32'hB7, 1'b0, 1'b1, 1'b0, 1'b1, 32'h14, 3'd4};

        // 1: steady stream, done every third cycle
        do_reset();
        for (int n = 0; n < 8; n++) begin
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
            cyc(1'b1, 32'hA0 + n, 1'b1, 1'b1);
`ifndef IFQ_BYPASS_EN
            if (n == 0) chk("latency_valid", {63'h0, ifq.if_valid_o}, 64'h1);
`endif
        end
        drain(8);

        // 2: fill to FULL with decode stalled, then a single pop
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].done, tbl[i].inst, tbl[i].ready, tbl[i].acc);
            chk($sformatf("tbl%0d_req", i), {63'h0, ifq.pc_req_o}, {63'h0, tbl[i].exp_req});
            chk($sformatf("tbl%0d_valid", i), {63'h0, ifq.if_valid_o}, {63'h0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d_pc", i), {32'h0, ifq.pc_o}, {32'h0, tbl[i].exp_pc});
            chk($sformatf("tbl%0d_cnt", i), {61'h0, dut.u_fifo.count}, {61'h0, tbl[i].exp_cnt});
        end
        drain(10);

        // 3: jump with fetch of 0x8 outstanding -> discard next word
        do_reset();
        cyc(1'b1, 32'hC0, 1'b0, 1'b1);
        cyc(1'b1, 32'hC1, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t3_pc_before", {32'h0, ifq.pc_o}, 64'h8);
        jmp(32'h100, 1'b0);
        chk("t3_valid", {63'h0, ifq.if_valid_o}, 64'h0);
        chk("t3_req_discard", {63'h0, ifq.pc_req_o}, 64'h0);
        chk("t3_pc", {32'h0, ifq.pc_o}, 64'h100);
        cyc(1'b1, 32'hDEAD, 1'b1, 1'b0);
        chk("t3_drop_valid", {63'h0, ifq.if_valid_o}, 64'h0);
        chk("t3_refetch_req", {63'h0, ifq.pc_req_o}, 64'h1);
        cyc(1'b1, 32'hC2, 1'b0, 1'b1);
        chk("t3_head", {ifq.if_pc_o, ifq.if_inst_o}, {32'h100, 32'hC2});
        drain(4);

        // 4: jump with done in the same cycle, then jump while FULL
        do_reset();
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        jmp(32'h200, 1'b1);
        chk("t4_pc", {32'h0, ifq.pc_o}, 64'h200);
        chk("t4_req", {63'h0, ifq.pc_req_o}, 64'h1);
        chk("t4_valid", {63'h0, ifq.if_valid_o}, 64'h0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hD0 + i, 1'b0, 1'b1);
        chk("t4_full_req", {63'h0, ifq.pc_req_o}, 64'h0);
        jmp(32'h300, 1'b0);
        chk("t4_full_jump_req", {63'h0, ifq.pc_req_o}, 64'h1);
        chk("t4_full_jump_pc", {32'h0, ifq.pc_o}, 64'h300);
        cyc(1'b1, 32'hD9, 1'b0, 1'b1);
        chk("t4_head", {ifq.if_pc_o, ifq.if_inst_o}, {32'h300, 32'hD9});
        drain(4);

        // 5: simultaneous push and pop at count 2 across pointer wrap
        do_reset();
        cyc(1'b1, 32'hE0, 1'b0, 1'b1);
        cyc(1'b1, 32'hE1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'hE2 + i, 1'b1, 1'b1);
            chk($sformatf("t5_cnt%0d", i), {61'h0, dut.u_fifo.count}, 64'h2);
        end
        drain(4);

        // 6: global pause mid-stream
        do_reset();
        cyc(1'b1, 32'hF0, 1'b0, 1'b1);
        cyc(1'b1, 32'hF1, 1'b0, 1'b1);
        rdy_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'hBAD, 1'b1, 1'b0);
            chk($sformatf("t6_req%0d", i), {63'h0, ifq.pc_req_o}, 64'h0);
            chk($sformatf("t6_pc%0d", i), {32'h0, ifq.pc_o}, 64'h8);
            chk($sformatf("t6_head%0d", i), {ifq.if_pc_o, ifq.if_inst_o}, {32'h0, 32'hF0});
            chk($sformatf("t6_cnt%0d", i), {61'h0, dut.u_fifo.count}, 64'h2);
        end
        rdy_in = 1'b1;
        drain(4);
`ifdef IFQ_BYPASS_EN
        ifq.pc_done_i = 1'b1; ifq.inst_i = 32'h77; ifq.id_ready_i = 1'b1;
        exp_q.push_back({model_pc, 32'h77});
        #1;
        chk("byp_valid", {63'h0, ifq.if_valid_o}, 64'h1);
        chk("byp_word", {ifq.if_pc_o, ifq.if_inst_o}, {model_pc, 32'h77});
        model_pc = model_pc + 32'd4;
        step();
        ifq.pc_done_i = 1'b0;
        chk("byp_consumed", exp_q.size(), 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
